// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Puts the core's instruction-fetch port and data port onto one single-ported,
// multi-cycle memory bus. When both ports ask for the bus in the same core
// cycle, the data access goes first and the fetch goes second. Read data comes
// back through holding registers. One global stall freezes the whole pipeline
// until every access of the current core cycle has completed.
//
// Parameters
//   TIMEOUT   bus cycles to wait for bus_ack before forcing completion (2..255)
//   ERR_DATA  read data returned when a read times out
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   inst_ren, inst_addr     core instruction read request and address
//   inst_data               fetched instruction (holding register)
//   mem_ren, mem_wen        core data read / write request
//   mem_addr, mem_dout      data address, write data from the core
//   mem_din                 read data to the core (holding register)
//   stall                   freezes the core pipeline while requests are pending
//   bus_req, bus_we         bus request (held until ack/timeout), write strobe
//   bus_addr, bus_wdata     bus address and write data
//   bus_ack, bus_rdata      slave completion pulse and read data
//   bus_err                 sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction port
   input  logic        inst_ren,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   // data port
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   // pipeline control
   output logic        stall,
   // memory bus
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_INST = 2'd2
   } state_e;

   // The counter is 8 bits wide because TIMEOUT is at most 255.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e      state_q;
   logic        data_done_q;
   logic        inst_done_q;
   logic [7:0]  tmo_cnt_q;
   logic        bus_req_q;
   logic        bus_we_q;
   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;
   logic        bus_err_q;
   logic [31:0] inst_data_q;
   logic [31:0] mem_din_q;

   logic        data_pend;
   logic        inst_pend;
   logic        timeout_hit;
   logic        xfer_done;
   logic [31:0] rd_value;

   // ---------------------------------------------------------------------------
   // Pending requests, stall, and transfer completion
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default value at the top of the block. A path
   // that leaves a signal unassigned would make synthesis infer a latch.
   always_comb begin
      data_pend   = 1'b0;
      inst_pend   = 1'b0;
      timeout_hit = 1'b0;
      xfer_done   = 1'b0;
      rd_value    = ERR_DATA;

      data_pend = (mem_ren | mem_wen) & ~data_done_q;
      inst_pend = inst_ren & ~inst_done_q;

      // If an ack arrives on the last timeout cycle, the ack wins. The real
      // data is used and no error is raised.
      timeout_hit = (tmo_cnt_q == TMO_LAST) & ~bus_ack;
      xfer_done   = bus_ack | timeout_hit;
      rd_value    = bus_ack ? bus_rdata : ERR_DATA;
   end

   assign stall = data_pend | inst_pend;

   // ---------------------------------------------------------------------------
   // Arbitration FSM with registered bus outputs and holding registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then sample the same pre-edge values, so statement order cannot change
   // the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_done_q <= 1'b0;
         inst_done_q <= 1'b0;
         tmo_cnt_q   <= 8'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_err_q   <= 1'b0;
         inst_data_q <= 32'd0;
         mem_din_q   <= 32'd0;
      end else begin
         // When stall is low, the core advances at this edge. The completion
         // record of the finished core cycle is then discarded. Done flags are
         // only set while stall is high, so the two never collide.
         if (!stall) begin
            data_done_q <= 1'b0;
            inst_done_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               // Data has priority, so a load/store is issued before the fetch
               // of the same core cycle. Any stray ack seen here is ignored.
               if (data_pend) begin
                  state_q     <= ST_DATA;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= mem_wen;
                  bus_addr_q  <= mem_addr;
                  bus_wdata_q <= mem_dout;
                  tmo_cnt_q   <= 8'd0;
               end else if (inst_pend) begin
                  state_q     <= ST_INST;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= inst_addr;
                  tmo_cnt_q   <= 8'd0;
               end
            end

            ST_DATA: begin
               if (xfer_done) begin
                  data_done_q <= 1'b1;
                  // A request with both ren and wen set runs as a write.
                  // In that case the read holding register is left untouched.
                  if (!bus_we_q) begin
                     mem_din_q <= rd_value;
                  end
                  if (timeout_hit) begin
                     bus_err_q <= 1'b1;
                  end
                  if (inst_pend) begin
                     // Go straight to the fetch without dropping bus_req.
                     state_q    <= ST_INST;
                     bus_req_q  <= 1'b1;
                     bus_we_q   <= 1'b0;
                     bus_addr_q <= inst_addr;
                     tmo_cnt_q  <= 8'd0;
                  end else begin
                     state_q   <= ST_IDLE;
                     bus_req_q <= 1'b0;
                     bus_we_q  <= 1'b0;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end

            ST_INST: begin
               if (xfer_done) begin
                  inst_done_q <= 1'b1;
                  inst_data_q <= rd_value;
                  if (timeout_hit) begin
                     bus_err_q <= 1'b1;
                  end
                  state_q   <= ST_IDLE;
                  bus_req_q <= 1'b0;
                  bus_we_q  <= 1'b0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end

            default: begin
               state_q   <= ST_IDLE;
               bus_req_q <= 1'b0;
               bus_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_err   = bus_err_q;
   assign inst_data = inst_data_q;
   assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter (TIMEOUT = 4).
//
// The stimulus process issues one core cycle of requests at a time. For each
// one it pushes two kinds of expectation. Each bus access goes to a slave-plan
// queue, and the stall length, holding registers and error flag for that core
// cycle go to a result queue. A bus-slave process pops a plan whenever a new
// bus request appears and checks it. A monitor process pops a result whenever
// a stall episode ends and compares it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int unsigned TMO  = 4;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic        clk;
   logic        rst_n;
   logic        inst_ren;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   mem_port_arbiter #(
      .TIMEOUT  (TMO),
      .ERR_DATA (ERRD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inst_ren  (inst_ren),
      .inst_addr (inst_addr),
      .inst_data (inst_data),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .stall     (stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;     // cycles after bus_req before ack; >= TMO: never
      logic [31:0] rdata;
   } bus_plan_t;

   typedef struct {
      int          stall_cyc;
      logic [31:0] mem_din;
      logic [31:0] inst_data;
      logic        err;
   } result_t;

   bus_plan_t plan_q[$];
   result_t   exp_q[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b1;

   // Reference state: what the holding registers and error flag must hold.
   logic [31:0] m_mem_din   = 32'd0;
   logic [31:0] m_inst_data = 32'd0;
   logic        m_err       = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // A bus access occupies min(lat, TMO-1) + 1 cycles. It times out when no
   // ack arrives by count TMO-1.
   function automatic int access_cycles(input int lat);
      return (lat >= int'(TMO)) ? int'(TMO) : lat + 1;
   endfunction

   // Issue one core cycle of requests and hold the inputs until stall drops.
   task automatic do_step(input bit d_rd, input bit d_wr, input bit i_rd,
                          input logic [31:0] maddr, input logic [31:0] mdout,
                          input logic [31:0] iaddr,
                          input int lat_d, input int lat_i,
                          input logic [31:0] rd_d, input logic [31:0] rd_i);
      result_t   r;
      bus_plan_t p;
      int        cyc;
      int        n;
      if (!(d_rd || d_wr || i_rd)) return;
      cyc = 1;  // the cycle in which the request is first visible
      if (d_rd || d_wr) begin
         p = '{we: d_wr, addr: maddr, wdata: mdout, lat: lat_d, rdata: rd_d};
         plan_q.push_back(p);
         cyc += access_cycles(lat_d);
         if (lat_d >= int'(TMO)) m_err = 1'b1;
         if (!d_wr) m_mem_din = (lat_d >= int'(TMO)) ? ERRD : rd_d;
      end
      if (i_rd) begin
         p = '{we: 1'b0, addr: iaddr, wdata: 32'd0, lat: lat_i, rdata: rd_i};
         plan_q.push_back(p);
         cyc += access_cycles(lat_i);
         if (lat_i >= int'(TMO)) m_err = 1'b1;
         m_inst_data = (lat_i >= int'(TMO)) ? ERRD : rd_i;
      end
      r = '{stall_cyc: cyc, mem_din: m_mem_din, inst_data: m_inst_data, err: m_err};
      exp_q.push_back(r);

      @(negedge clk);
      mem_ren   = d_rd;
      mem_wen   = d_wr;
      mem_addr  = maddr;
      mem_dout  = mdout;
      inst_ren  = i_rd;
      inst_addr = iaddr;
      n = 0;
      forever begin
         #3;
         if (!stall) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL stall_stuck: stall still 1 after %0d cycles, expected release after %0d", n, cyc);
            finish_sim();
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mem_ren  = 1'b0;
         mem_wen  = 1'b0;
         inst_ren = 1'b0;
         mem_addr = $urandom;
         inst_addr = $urandom;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Bus slave: acks each access per its plan and checks the bus fields
   // ---------------------------------------------------------------------------
   initial begin
      bus_plan_t cur;
      int        cyc;
      bit        active;
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      active    = 1'b0;
      cyc       = 0;
      cur       = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, lat: 0, rdata: 32'd0};
      forever begin
         @(posedge clk);
         #1;
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
         if (!rst_n) begin
            active = 1'b0;
            continue;
         end
         if (active) begin
            cyc++;
         end else if (bus_req) begin
            if (plan_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_unexpected: bus_req at addr 0x%08h, expected no access", bus_addr);
               cur = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, lat: 0, rdata: 32'd0};
            end else begin
               cur = plan_q.pop_front();
               check("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
               check("bus_addr", bus_addr, cur.addr);
               if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
            end
            active = 1'b1;
            cyc    = 0;
         end
         if (active) begin
            if (cyc == cur.lat) begin
               bus_ack   = 1'b1;
               bus_rdata = cur.rdata;
               active    = 1'b0;
            end else if (cyc == int'(TMO) - 1) begin
               active = 1'b0;   // the arbiter forces completion at this edge
            end
         end else if (!bus_req && ($urandom_range(0, 3) == 0)) begin
            bus_ack = 1'b1;     // stray ack while idle must be ignored
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: at the end of each stall episode, compare against the model
   // ---------------------------------------------------------------------------
   initial begin
      int      run;
      result_t r;
      run = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!mon_en || !rst_n) begin
            run = 0;
            continue;
         end
         if (stall) begin
            run++;
         end else if (run > 0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result_unexpected: stall episode of %0d cycles, expected none", run);
            end else begin
               r = exp_q.pop_front();
               check("stall_cycles", 32'(run), 32'(r.stall_cyc));
               check("mem_din", mem_din, r.mem_din);
               check("inst_data", inst_data, r.inst_data);
               check("bus_err", {31'd0, bus_err}, {31'd0, r.err});
            end
            run = 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst_n     = 1'b0;
      inst_ren  = 1'b0;
      inst_addr = 32'd0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = 32'd0;
      mem_dout  = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_mem_din", mem_din, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Fetch alone. The ack comes 3 cycles after bus_req, which is exactly
      // the last timeout cycle: the real data wins and there is no error.
      do_step(0, 0, 1, 32'd0, 32'd0, 32'h100, 0, 3, 32'd0, 32'h20080005);
      // Load and fetch together, immediate acks, no bus_req gap between them.
      do_step(1, 0, 1, 32'h200, 32'd0, 32'h104, 0, 0, 32'h11, 32'h22);
      // Store twice in a row. The second store only stalls if the done flags
      // were cleared at the stall-free edge.
      do_step(0, 1, 0, 32'h300, 32'hCAFE0001, 32'd0, 1, 0, 32'd0, 32'd0);
      do_step(0, 1, 0, 32'h300, 32'hCAFE0001, 32'd0, 0, 0, 32'd0, 32'd0);
      // Both ren and wen set: runs as a write, and mem_din keeps its value.
      do_step(1, 1, 0, 32'h304, 32'h0BADF00D, 32'd0, 2, 0, 32'h77, 32'd0);
      // Fetch with no ack: forced completion, ERR_DATA, sticky bus_err.
      do_step(0, 0, 1, 32'd0, 32'd0, 32'h500, 0, 1000, 32'd0, 32'd0);
      idle(1);
      do_step(1, 0, 0, 32'h600, 32'd0, 32'd0, 1, 0, 32'h600D, 32'd0);
      idle(1);

      // Asynchronous reset in the middle of a data access.
      mon_en = 1'b0;
      plan_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'd0, lat: 1000, rdata: 32'd0});
      @(negedge clk);
      mem_ren  = 1'b1;
      mem_addr = 32'h400;
      @(posedge clk);
      #2;
      check("mid_bus_req", {31'd0, bus_req}, 32'd1);
      #2;
      rst_n    = 1'b0;
      mem_ren  = 1'b0;
      inst_ren = 1'b0;
      #1;
      check("arst_bus_req", {31'd0, bus_req}, 32'd0);
      check("arst_bus_addr", bus_addr, 32'd0);
      check("arst_bus_err", {31'd0, bus_err}, 32'd0);
      check("arst_inst_data", inst_data, 32'd0);
      check("arst_mem_din", mem_din, 32'd0);
      check("arst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      plan_q.delete();
      exp_q.delete();
      m_mem_din   = 32'd0;
      m_inst_data = 32'd0;
      m_err       = 1'b0;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      idle(1);
      do_step(0, 0, 1, 32'd0, 32'd0, 32'h0, 0, 1, 32'd0, 32'h3C010000);

      // Random core cycles with random slave latencies, including timeouts.
      for (int i = 0; i < 60; i++) begin
         int kind;
         bit d_rd;
         bit d_wr;
         bit i_rd;
         kind = int'($urandom_range(0, 4));
         d_rd = (kind == 1) || (kind == 3);
         d_wr = (kind == 2) || (kind == 4);
         i_rd = (kind == 0) || (kind == 3) || (kind == 4);
         if (d_wr && ($urandom_range(0, 5) == 0)) d_rd = 1'b1;
         do_step(d_rd, d_wr, i_rd, {$urandom} & 32'hFFFF_FFFC, $urandom,
                 {$urandom} & 32'hFFFF_FFFC,
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 $urandom, $urandom);
         idle(int'($urandom_range(0, 2)));
      end

      idle(5);
      check("results_left", 32'(exp_q.size()), 32'd0);
      check("plans_left", 32'(plan_q.size()), 32'd0);
      finish_sim();
   end

endmodule
